// File: rtl/logic_unit_pkg.sv
// Shared types for the logic unit pipeline stage.
// Op-code enum and op-count constant used by the top and op sub-module.
package logic_unit_pkg;

    localparam int OP_COUNT = 8;
    localparam int OP_W     = $clog2(OP_COUNT);

    typedef enum logic [OP_W-1:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_XOR  = 3'd2,
        OP_NAND = 3'd3,
        OP_NOR  = 3'd4,
        OP_XNOR = 3'd5,
        OP_NOT  = 3'd6,
        OP_PASS = 3'd7
    } op_e;

endpackage

// File: rtl/logic_unit_op.sv
// Combinational bitwise function f(op, a, b) over WIDTH bits.
// Every result bit depends only on the same bit of a and b.
module logic_unit_op
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    op_e op_sel;
    assign op_sel = op_e'(op);

    always_comb begin
        y = '0;
        unique case (op_sel)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_NAND: y = ~(a & b);
            OP_NOR:  y = ~(a | b);
            OP_XNOR: y = ~(a ^ b);
            OP_NOT:  y = ~a;
            OP_PASS: y = a;
        endcase
    end

endmodule

// File: rtl/logic_unit_pipe.sv
// Registered bitwise logic stage with accumulator and valid/ready output.
// Define LOGIC_UNIT_FLAGS_EN to add registered out_zero/out_ones flags.
module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int               WIDTH    = 16,
    parameter logic [WIDTH-1:0] ACC_INIT = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    input  logic             in_acc,
    input  logic             acc_clear,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef LOGIC_UNIT_FLAGS_EN
    output logic             out_zero,
    output logic             out_ones,
`endif
    output logic [WIDTH-1:0] out_data
);

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] res;
    logic             fire_in;
    logic             fire_out;

    // Full throughput: a held result may drain and be replaced in one cycle.
    assign in_ready = ~out_valid | out_ready;
    assign fire_in  = in_valid & in_ready;
    assign fire_out = out_valid & out_ready;
    assign opa      = in_acc ? acc : in_a;

    logic_unit_op #(
        .WIDTH (WIDTH)
    ) u_op (
        .op (in_op),
        .a  (opa),
        .b  (in_b),
        .y  (res)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (fire_in) begin
            out_valid <= 1'b1;
            out_data  <= res;
        end else if (fire_out) begin
            out_valid <= 1'b0;
        end
    end

    // Clear wins over the update; the op itself already saw the old value.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc <= ACC_INIT;
        end else if (acc_clear) begin
            acc <= ACC_INIT;
        end else if (fire_in) begin
            acc <= res;
        end
    end

`ifdef LOGIC_UNIT_FLAGS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            out_zero <= 1'b1;
            out_ones <= 1'b0;
        end else if (fire_in) begin
            out_zero <= (res == '0);
            out_ones <= (res == {WIDTH{1'b1}});
        end
    end
`endif

    a_in_hold: assert property (
        @(posedge clk) disable iff (reset)
        (in_valid && !in_ready) |=>
            ($stable(in_a) && $stable(in_b) &&
             $stable(in_op) && $stable(in_acc))
    );

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed self-checking bench for logic_unit_pipe at WIDTH=16.
// Flag checks run only when LOGIC_UNIT_FLAGS_EN is defined.
module tb_logic_unit_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic [2:0]  in_op;
    logic        in_acc;
    logic        acc_clear;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
`ifdef LOGIC_UNIT_FLAGS_EN
    logic        out_zero;
    logic        out_ones;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    logic_unit_pipe #(
        .WIDTH (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .in_acc    (in_acc),
        .acc_clear (acc_clear),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef LOGIC_UNIT_FLAGS_EN
        .out_zero  (out_zero),
        .out_ones  (out_ones),
`endif
        .out_data  (out_data)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] exp_ops [8];

    initial begin
        exp_ops[0] = 16'hF000; exp_ops[1] = 16'hFFF0;
        exp_ops[2] = 16'h0FF0; exp_ops[3] = 16'h0FFF;
        exp_ops[4] = 16'h000F; exp_ops[5] = 16'hF00F;
        exp_ops[6] = 16'h0F0F; exp_ops[7] = 16'hF0F0;

        reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0;
        in_op = 3'd0; in_acc = 1'b0; acc_clear = 1'b0;
        out_ready = 1'b1;
        tick(); tick();
        reset = 1'b0;
        tick();
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_data",  64'(out_data),  64'd0);
        chk("rst_ready", 64'(in_ready),  64'd1);
`ifdef LOGIC_UNIT_FLAGS_EN
        chk("rst_zero", 64'(out_zero), 64'd1);
        chk("rst_ones", 64'(out_ones), 64'd0);
`endif

        // All eight ops streamed back to back: one result per cycle.
        in_valid = 1'b1; in_a = 16'hF0F0; in_b = 16'hFF00;
        for (int i = 0; i < 8; i++) begin
            in_op = 3'(i);
            tick();
            chk($sformatf("op%0d_valid", i), 64'(out_valid), 64'd1);
            chk($sformatf("op%0d_data", i),  64'(out_data),  64'(exp_ops[i]));
        end
        in_valid = 1'b0;
        tick();
        chk("drain_valid", 64'(out_valid), 64'd0);
        chk("drain_hold",  64'(out_data),  64'hF0F0);

        // Accumulate from the reset value.
        reset = 1'b1; tick(); reset = 1'b0;
        in_valid = 1'b1; in_acc = 1'b1; in_op = 3'd0; in_b = 16'h00FF;
        tick();
        chk("acc1", 64'(out_data), 64'h00FF);
        in_b = 16'h0F0F;
        tick();
        chk("acc2", 64'(out_data), 64'h000F);
        in_valid = 1'b0; acc_clear = 1'b1;
        tick();
        acc_clear = 1'b0; in_valid = 1'b1; in_b = 16'h1234;
        tick();
        chk("acc_clr", 64'(out_data), 64'h1234);
        // Clear together with an accumulate: op sees the old value.
        in_op = 3'd7; acc_clear = 1'b1;
        tick();
        chk("acc_clr_fire", 64'(out_data), 64'h1234);
        acc_clear = 1'b0;
        tick();
        chk("acc_after_clr", 64'(out_data), 64'hFFFF);

        // Backpressure.
        in_acc = 1'b0; in_a = 16'hAAAA; in_op = 3'd7;
        tick();
        chk("bp_first", 64'(out_data), 64'hAAAA);
        out_ready = 1'b0; in_a = 16'h5555;
        #1;
        chk("bp_ready0", 64'(in_ready), 64'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("bp_hold%0d", i), 64'(out_data), 64'hAAAA);
            chk($sformatf("bp_vld%0d", i),  64'(out_valid), 64'd1);
            chk($sformatf("bp_rdy%0d", i),  64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 64'(in_ready), 64'd1);
        tick();
        chk("bp_replace", 64'(out_data), 64'h5555);
        chk("bp_replace_vld", 64'(out_valid), 64'd1);

        // Reset while a result is stalled.
        in_valid = 1'b0; out_ready = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mrst_valid", 64'(out_valid), 64'd0);
        chk("mrst_data",  64'(out_data),  64'd0);
        out_ready = 1'b1; in_valid = 1'b1; in_acc = 1'b1;
        in_op = 3'd0; in_b = 16'h1234;
        tick();
        chk("mrst_acc", 64'(out_data), 64'h1234);

`ifdef LOGIC_UNIT_FLAGS_EN
        in_acc = 1'b0; in_a = 16'h0000; in_op = 3'd7;
        tick();
        chk("flag_zero_z", 64'(out_zero), 64'd1);
        chk("flag_zero_o", 64'(out_ones), 64'd0);
        in_op = 3'd6;
        tick();
        chk("flag_ones_z", 64'(out_zero), 64'd0);
        chk("flag_ones_o", 64'(out_ones), 64'd1);
`endif
        in_valid = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
